// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared piece encodings, controller states and scan length
//
// Contents:
//   PIECE_EMPTY/PIECE_BLUE/PIECE_RED  2-bit piece / player / verdict encodings
//   ctrl_state_t                      win_check_controller state enum
//   SCAN_CYCLES_DEFAULT               226 pieces + 2 cycles recognizer pipeline
package connect4_pkg;

  localparam logic [1:0] PIECE_EMPTY = 2'b00;
  localparam logic [1:0] PIECE_BLUE  = 2'b01;
  localparam logic [1:0] PIECE_RED   = 2'b10;

  localparam int SCAN_CYCLES_DEFAULT = 228;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_RESULT = 3'd3,
    ST_OVER   = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - loadable down-counter that saturates at zero
//
// Ports:
//   clock       in   system clock
//   reset       in   synchronous, active-high; clears the count
//   load        in   load load_value (has priority over en)
//   load_value  in   WIDTH  value to load
//   en          in   decrement by one while nonzero
//   zero        out  count is zero
module scan_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Stops at zero instead of wrapping, so a stray en after expiry is harmless.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/win_check_controller.sv
// rtl/win_check_controller.sv - runs one recognizer scan per move and resolves win/draw/turn
//
// Optional feature macro: WIN_CHECK_EARLY_EXIT_EN (a nonzero verdict during SCAN
// ends the scan on the next edge). Undefined: every scan runs SCAN_CYCLES cycles.
//
// Ports:
//   clock           in   system clock
//   reset           in   synchronous, active-high
//   move_done       in   one-cycle pulse, a piece was placed (honoured in IDLE only)
//   board_full      in   no empty cells remain (used in RESULT only)
//   recog_out       in   2  recognizer verdict: 00 none, 01 blue, 10 red, 11 treated as 00
//   recog_enable    out  recognizer enable; low reloads shifter and clears recognizer
//   busy            out  high in SCAN, CHECK, RESULT
//   done            out  one-cycle pulse when the move's verdict is final
//   winner          out  2  registered winner
//   draw            out  registered draw flag
//   current_player  out  2  player to move (01 blue, 10 red)
//   game_over       out  sticky until reset
module win_check_controller
  import connect4_pkg::*;
#(
  parameter int SCAN_CYCLES = SCAN_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       move_done,
  input  logic       board_full,
  input  logic [1:0] recog_out,
  output logic       recog_enable,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic       draw,
  output logic [1:0] current_player,
  output logic       game_over
);

  localparam int CW = $clog2(SCAN_CYCLES);
  localparam logic [CW-1:0] LOAD_VALUE = CW'(SCAN_CYCLES - 1);

  ctrl_state_t state, state_next;
  logic [1:0]  verdict;
  logic [1:0]  recog_clean;
  logic        timer_load;
  logic        timer_zero;

  // 11 is not a legal verdict; fold it into "no winner" everywhere.
  assign recog_clean = (recog_out == 2'b11) ? PIECE_EMPTY : recog_out;

  scan_timer #(
    .WIDTH(CW)
  ) u_scan_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (timer_load),
    .load_value(LOAD_VALUE),
    .en        (state == ST_SCAN),
    .zero      (timer_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (move_done) state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (timer_zero) state_next = ST_CHECK;
`ifdef WIN_CHECK_EARLY_EXIT_EN
        if (recog_clean != PIECE_EMPTY) state_next = ST_CHECK;
`endif
      end
      ST_CHECK: begin
        state_next = ST_RESULT;
      end
      ST_RESULT: begin
        if ((verdict != PIECE_EMPTY) || board_full) state_next = ST_OVER;
        else state_next = ST_IDLE;
      end
      ST_OVER: begin
        state_next = ST_OVER;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Enable drops in CHECK, so the recognizer clears on the edge after the
  // verdict is captured; CHECK+RESULT guarantee a two-cycle enable gap.
  always_comb begin
    recog_enable = (state == ST_SCAN);
    busy         = (state == ST_SCAN) || (state == ST_CHECK) || (state == ST_RESULT);
    done         = (state == ST_RESULT);
    timer_load   = (state == ST_IDLE) && move_done;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      verdict        <= PIECE_EMPTY;
      winner         <= PIECE_EMPTY;
      draw           <= 1'b0;
      current_player <= PIECE_BLUE;
      game_over      <= 1'b0;
    end else begin
      if (state == ST_CHECK) begin
        verdict <= recog_clean;
      end
      if (state == ST_RESULT) begin
        if (verdict != PIECE_EMPTY) begin
          winner    <= verdict;
          game_over <= 1'b1;
        end else if (board_full) begin
          draw      <= 1'b1;
          game_over <= 1'b1;
        end else begin
          current_player <= (current_player == PIECE_BLUE) ? PIECE_RED : PIECE_BLUE;
        end
      end
    end
  end

endmodule

// File: tb/tb_win_check_controller.sv
// tb/tb_win_check_controller.sv - self-checking bench for win_check_controller
module tb_win_check_controller;

  localparam int SC = 228;

  logic       clock = 1'b0;
  logic       reset;
  logic       move_done;
  logic       board_full;
  logic [1:0] recog_out;
  logic       recog_enable;
  logic       busy;
  logic       done;
  logic [1:0] winner;
  logic       draw;
  logic [1:0] current_player;
  logic       game_over;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference game state
  int exp_player;
  int exp_winner;
  int exp_draw;
  int exp_over;

  // observations of the latest move, absolute cycle numbers
  int g_t0;
  int g_first;
  int g_last;
  int g_done;

  win_check_controller #(.SCAN_CYCLES(SC)) dut (
    .clock         (clock),
    .reset         (reset),
    .move_done     (move_done),
    .board_full    (board_full),
    .recog_out     (recog_out),
    .recog_enable  (recog_enable),
    .busy          (busy),
    .done          (done),
    .winner        (winner),
    .draw          (draw),
    .current_player(current_player),
    .game_over     (game_over)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    exp_player = 1;
    exp_winner = 0;
    exp_draw   = 0;
    exp_over   = 0;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic apply_reset(input int n, input logic md);
    reset = 1'b1; move_done = md; recog_out = 2'b00; board_full = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
    reset = 1'b0; move_done = 1'b0;
    model_reset();
  endtask

  task automatic check_settled(input string tag);
    @(negedge clock);
    check({tag, ".recog_enable"}, recog_enable, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".winner"}, winner, exp_winner);
    check({tag, ".draw"}, draw, exp_draw);
    check({tag, ".player"}, current_player, exp_player);
    check({tag, ".game_over"}, game_over, exp_over);
    @(posedge clock); #1;
  endtask

  // One move: recog_out = v from relative cycle v_start on; optional second
  // move_done somewhere inside the expected scan window.
  task automatic run_move(input string tag, input logic [1:0] v, input int v_start,
                          input logic full, input logic extra_md);
    int first_en = -1, last_en = -1, en_cnt = 0, done_k = -1, done_cnt = 0;
    int last_exp, extra_at, vs, verdict;
    vs = (v == 2'b11) ? 0 : int'(v);
`ifdef WIN_CHECK_EARLY_EXIT_EN
    last_exp = (vs != 0 && v_start <= SC) ? v_start : SC;
`else
    last_exp = SC;
`endif
    verdict  = (v_start <= last_exp + 1) ? vs : 0;
    extra_at = extra_md ? int'($urandom_range(1, last_exp)) : -1;
    g_t0 = cyc;
    for (int k = 0; k <= SC + 8; k++) begin
      move_done  = (k == 0) || (k == extra_at);
      recog_out  = (k >= v_start) ? v : 2'b00;
      board_full = full;
      @(negedge clock);
      if (recog_enable) begin
        if (first_en < 0) first_en = k;
        last_en = k;
        en_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      @(posedge clock); #1;
    end
    move_done = 1'b0; recog_out = 2'b00; board_full = 1'b0;
    g_first = g_t0 + first_en;
    g_last  = g_t0 + last_en;
    g_done  = g_t0 + done_k;
    if (exp_over != 0) begin
      check({tag, ".no_scan_en"}, en_cnt, 0);
      check({tag, ".no_scan_done"}, done_cnt, 0);
    end else begin
      check({tag, ".first_en"}, first_en, 1);
      check({tag, ".last_en"}, last_en, last_exp);
      check({tag, ".en_cycles"}, en_cnt, last_exp);
      check({tag, ".done_at"}, done_k, last_exp + 2);
      check({tag, ".done_pulses"}, done_cnt, 1);
      if (verdict != 0) begin
        exp_winner = verdict; exp_over = 1;
      end else if (full) begin
        exp_draw = 1; exp_over = 1;
      end else begin
        exp_player = 3 - exp_player;
      end
    end
    check_settled(tag);
  endtask

  task automatic run_reset_mid(input int at);
    int en_after = 0, done_seen = 0;
    for (int k = 0; k <= at; k++) begin
      move_done = (k == 0); recog_out = 2'b00; board_full = 1'b0;
      if (k == at) begin
        @(negedge clock);
        check("midreset.en_before", recog_enable, 1);
        reset = 1'b1;
      end
      @(posedge clock); #1;
    end
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (recog_enable) en_after++;
      if (done) done_seen++;
      @(posedge clock); #1;
    end
    check("midreset.en_after", en_after, 0);
    check("midreset.done", done_seen, 0);
    check_settled("midreset");
  endtask

  initial begin
    reset = 1'b1; move_done = 1'b0; board_full = 1'b0; recog_out = 2'b00;
    model_reset();

    apply_reset(3, 1'b0);
    check_settled("reset");

    while (cyc < 10) begin @(posedge clock); #1; end
    run_move("timing", 2'b00, SC + 50, 1'b0, 1'b0);
    check("timing.abs_first", g_first, 11);
    check("timing.abs_last", g_last, 238);
    check("timing.abs_done", g_done, 240);
    check("timing.player", current_player, 2);

    run_move("draw", 2'b00, SC + 50, 1'b1, 1'b0);
    run_move("after_draw", 2'b00, SC + 50, 1'b0, 1'b0);

    apply_reset(1, 1'b1);
    check_settled("reset_with_move");

    run_reset_mid(50);

    run_move("win", 2'b10, 100, 1'b0, 1'b1);
    run_move("after_win", 2'b00, SC + 50, 1'b0, 1'b0);

    apply_reset(2, 1'b0);
    run_move("illegal", 2'b11, 5, 1'b0, 1'b0);

    apply_reset(2, 1'b0);
    run_move("early", 2'b01, 20, 1'b0, 1'b0);

    apply_reset(2, 1'b0);
    for (int i = 0; i < 16; i++) begin
      logic [1:0] v;
      if (exp_over != 0 && $urandom_range(0, 1) == 0) apply_reset(1, 1'b0);
      v = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
      run_move("random", v, int'($urandom_range(1, SC + 3)),
               ($urandom_range(0, 99) < 15), ($urandom_range(0, 9) < 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
